// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: NOP encoding,
// default text-segment base and fetch FSM state encodings.
package instruction_fetch_pkg;

  localparam logic [31:0] NOP_INSTR         = 32'h0000_0000;
  localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0040_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_stats.sv
// Fetch/stall event counters for the instruction fetch stage.
// Only instantiated when FETCH_STATS_EN is defined. Counters wrap.
module fetch_stats (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_i,
  input  logic        stall_i,
  output logic [31:0] fetch_count_o,
  output logic [31:0] stall_count_o
);

  logic [31:0] fetch_count_q;
  logic [31:0] stall_count_q;

  // Count qualified fetch and stall events; events are gated by the caller.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      if (fetch_i) fetch_count_q <= fetch_count_q + 32'd1;
      if (stall_i) stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign fetch_count_o = fetch_count_q;
  assign stall_count_o = stall_count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, redirect selection, IF/ID
// pipeline register and a BOOT/RUN/HALT sequencer.
// Optional macro FETCH_STATS_EN adds FetchCount/StallCount outputs.
//
// state | meaning
// BOOT  | PC parked at TEXT_BASE, IF/ID bubble, leaves to RUN next edge
// RUN   | normal fetch; out-of-range PC sends FSM to HALT
// HALT  | PC frozen, IF/ID bubble every cycle, only reset exits
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = DATA_WIDTH'(TEXT_BASE_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic                  BranchTaken,
  input  logic [DATA_WIDTH-1:0] BranchTarget,
  input  logic                  Jump,
  input  logic [DATA_WIDTH-1:0] JumpTarget,
  output logic [DATA_WIDTH-1:0] ImemAddress,
  input  logic [DATA_WIDTH-1:0] ImemInstruction,
  output logic [DATA_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0] IFID_Instruction,
  output logic [DATA_WIDTH-1:0] IFID_PCPlus4,
  output logic                  IFID_Valid,
  output logic                  AddrError
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]           FetchCount,
  output logic [31:0]           StallCount
`endif
);

  localparam logic [DATA_WIDTH-1:0] MEM_BYTES = DATA_WIDTH'(MEMORY_DEPTH * 4);
  localparam logic [DATA_WIDTH-1:0] BUBBLE    = DATA_WIDTH'(NOP_INSTR);

  fetch_state_e          state_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] ifid_instr_q;
  logic [DATA_WIDTH-1:0] ifid_pc4_q;
  logic                  ifid_valid_q;
  logic                  addr_err_q;

  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] pc_offset;
  logic [DATA_WIDTH-1:0] target_raw;
  logic [DATA_WIDTH-1:0] pc_d;
  logic                  redirect;
  logic                  out_of_range;
  logic                  misaligned_d;

  // Next-PC selection (branch beats jump) and fetch range check.
  always_comb begin
    pc_plus4     = pc_q + DATA_WIDTH'(4);
    pc_offset    = pc_q - TEXT_BASE;
    out_of_range = (pc_q < TEXT_BASE) || (pc_offset >= MEM_BYTES);
    redirect     = BranchTaken || Jump;
    target_raw   = BranchTaken ? BranchTarget : JumpTarget;
    misaligned_d = redirect && (target_raw[1:0] != 2'b00);
    pc_d         = redirect ? {target_raw[DATA_WIDTH-1:2], 2'b00} : pc_plus4;
  end

  // Fetch sequencer with PC and IF/ID registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_BOOT;
      pc_q         <= TEXT_BASE;
      ifid_instr_q <= BUBBLE;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_BOOT: begin
          state_q      <= ST_RUN;
          ifid_instr_q <= BUBBLE;
          ifid_pc4_q   <= '0;
          ifid_valid_q <= 1'b0;
        end
        ST_RUN: begin
          if (out_of_range) begin
            // The offending word is never captured.
            state_q      <= ST_HALT;
            addr_err_q   <= 1'b1;
            ifid_instr_q <= BUBBLE;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
          end else begin
            if (!Stall) begin
              pc_q <= pc_d;
              if (misaligned_d) addr_err_q <= 1'b1;
            end
            if (Flush) begin
              ifid_instr_q <= BUBBLE;
              ifid_pc4_q   <= '0;
              ifid_valid_q <= 1'b0;
            end else if (!Stall) begin
              ifid_instr_q <= ImemInstruction;
              ifid_pc4_q   <= pc_plus4;
              ifid_valid_q <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          ifid_instr_q <= BUBBLE;
          ifid_pc4_q   <= '0;
          ifid_valid_q <= 1'b0;
        end
        default: state_q <= ST_BOOT;
      endcase
    end
  end

  assign ImemAddress      = pc_offset;
  assign PC               = pc_q;
  assign IFID_Instruction = ifid_instr_q;
  assign IFID_PCPlus4     = ifid_pc4_q;
  assign IFID_Valid       = ifid_valid_q;
  assign AddrError        = addr_err_q;

`ifdef FETCH_STATS_EN
  logic fetch_evt;
  logic stall_evt;

  // A fetch counts only when a real instruction lands in IF/ID.
  always_comb begin
    fetch_evt = (state_q == ST_RUN) && !out_of_range && !Stall && !Flush;
    stall_evt = (state_q == ST_RUN) && Stall;
  end

  fetch_stats u_fetch_stats (
    .clk           (clk),
    .reset         (reset),
    .fetch_i       (fetch_evt),
    .stall_i       (stall_evt),
    .fetch_count_o (FetchCount),
    .stall_count_o (StallCount)
  );
`endif

endmodule
